// File: rtl/adder_seq_ctrl.sv
// Two-requester sequencer that time-shares one external 8-bit adder, running BYTES-byte adds LSB first.
// Optional subtract mode is compiled in with `define SUB_EN (adds req0_sub / req1_sub).
module adder_seq_ctrl #(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [8*BYTES-1:0] req0_a,
    input  logic [8*BYTES-1:0] req0_b,
    input  logic               req0_ci,
`ifdef SUB_EN
    input  logic               req0_sub,
    input  logic               req1_sub,
`endif
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [8*BYTES-1:0] req1_a,
    input  logic [8*BYTES-1:0] req1_b,
    input  logic               req1_ci,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [8*BYTES-1:0] rsp_sum,
    output logic               rsp_co,
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    output logic               add_ci,
    input  logic [7:0]         add_sum,
    input  logic               add_co
);

    localparam int W  = 8 * BYTES;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    logic [W-1:0]  a_reg, b_reg;
    logic          ci_reg, carry_reg, last_grant_reg, sub_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    a_byte   [BYTES];
    logic [7:0]    b_byte   [BYTES];
    logic [7:0]    sum_reg  [BYTES];
    logic          grant0, grant1, grant_any, sub_sel;

`ifdef SUB_EN
    assign sub_sel = grant1 ? req1_sub : req0_sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Ready is gated by rst_n so nothing is acknowledged while reset is held.
    assign grant0    = rst_n && (state_reg == IDLE) && req0_valid && (!req1_valid || last_grant_reg);
    assign grant1    = rst_n && (state_reg == IDLE) && req1_valid && !grant0;
    assign grant_any = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
        assign a_byte[gi] = a_reg[8*gi +: 8];
        assign b_byte[gi] = b_reg[8*gi +: 8];
        assign rsp_sum[8*gi +: 8] = sum_reg[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_reg[gi] <= 8'h00;
            end else if (grant_any) begin
                sum_reg[gi] <= 8'h00;
            end else if (state_reg == RUN && cnt_reg == CW'(gi)) begin
                sum_reg[gi] <= add_sum;
            end
        end
    end

    // Subtraction feeds the inverted B byte; the initial carry of 1 is folded into ci_reg at grant.
    always_comb begin
        add_a  = 8'h00;
        add_b  = 8'h00;
        add_ci = 1'b0;
        if (state_reg == RUN) begin
            add_a  = a_byte[cnt_reg];
            add_b  = b_byte[cnt_reg] ^ {8{sub_reg}};
            add_ci = (cnt_reg == '0) ? ci_reg : carry_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_co         <= 1'b0;
            cnt_reg        <= '0;
            carry_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
            ci_reg         <= 1'b0;
            sub_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        state_reg      <= RUN;
                        cnt_reg        <= '0;
                        rsp_id         <= grant1;
                        last_grant_reg <= grant1;
                        a_reg          <= grant1 ? req1_a : req0_a;
                        b_reg          <= grant1 ? req1_b : req0_b;
                        ci_reg         <= sub_sel ? 1'b1 : (grant1 ? req1_ci : req0_ci);
                        sub_reg        <= sub_sel;
                    end
                end
                RUN: begin
                    carry_reg <= add_co;
                    if (cnt_reg == LAST) begin
                        rsp_co    <= add_co;
                        rsp_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (BYTES=4) with a behavioural 8-bit adder on the add_* port.
// Subtract-mode vectors run only when SUB_EN is defined.
module tb_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_ci;
    logic        req1_valid, req1_ready, req1_ci;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
`ifdef SUB_EN
    logic        req0_sub, req1_sub;
`endif
    logic        rsp_valid, rsp_ready, rsp_id, rsp_co;
    logic [31:0] rsp_sum;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_ci, add_co;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};

    adder_seq_ctrl #(.BYTES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ci    (req0_ci),
`ifdef SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ci    (req1_ci),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_co     (rsp_co),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_ci     (add_ci),
        .add_sum    (add_sum),
        .add_co     (add_co)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise one requester's valid, wait (bounded) for its ready, drop valid just after the accept edge.
    task automatic issue(input bit which, input logic [31:0] a, input logic [31:0] b, input logic ci);
        int w;
        @(negedge clk);
        if (!which) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ci = ci;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ci = ci;
        end
        #1;
        w = 0;
        while (!(which ? req1_ready : req0_ready) && w < 50) begin
            @(negedge clk); #1; w++;
        end
        chk("grant", 32'(which ? req1_ready : req0_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!which) req0_valid = 1'b0; else req1_valid = 1'b0;
        $display("issue req%0d a=%h b=%h ci=%0d", which, a, b, ci);
    endtask

    // Counts clock edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (rsp_valid) break;
            lat++;
        end while (lat < 50);
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        $display("rsp id=%0d sum=%h co=%0d lat=%0d", rsp_id, rsp_sum, rsp_co, lat);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat, cyc, n, last_hs;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
`ifdef SUB_EN
        req0_sub = 1'b0; req1_sub = 1'b0;
`endif
        rsp_ready = 1'b0;

        // Reset state, with req0_valid held high to show no ready leaks out during reset.
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_valid",  32'(rsp_valid),  32'd0);
        chk("rst_sum",    rsp_sum,         32'h0);
        chk("rst_co_id",  32'({rsp_co, rsp_id}), 32'd0);
        chk("rst_add",    32'({add_a, add_b, add_ci}), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Byte carry from byte 0 into byte 1; response 4 edges after accept.
        issue(1'b0, 32'h000000FF, 32'h00000001, 1'b0);
        @(negedge clk);
        chk("b0_add_a",  32'(add_a),  32'hFF);
        chk("b0_add_b",  32'(add_b),  32'h01);
        chk("b0_add_ci", 32'(add_ci), 32'd0);
        chk("run_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("b1_add_a",  32'(add_a),  32'h00);
        chk("b1_add_ci", 32'(add_ci), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t1_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_sum",   rsp_sum,         32'h00000100);
        chk("t1_co",    32'(rsp_co),     32'd0);
        chk("t1_id",    32'(rsp_id),     32'd0);
        consume();

        // Carry-in ripples through every byte.
        issue(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_rsp(lat);
        chk("t2_lat", 32'(lat),   32'd4);
        chk("t2_sum", rsp_sum,    32'h00000000);
        chk("t2_co",  32'(rsp_co), 32'd1);
        chk("t2_id",  32'(rsp_id), 32'd1);
        consume();

        // Both requesters continuously valid: alternating ids, issue interval 6.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h1;  req0_b = 32'h2;  req0_ci = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h20; req1_ci = 1'b1;
        rsp_ready = 1'b1;
        cyc = 0; n = 0; last_hs = 0;
        while (n < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                $display("rr rsp id=%0d sum=%h cyc=%0d", rsp_id, rsp_sum, cyc);
                chk("rr_id",  32'(rsp_id), 32'(n % 2));
                chk("rr_sum", rsp_sum, (n % 2 == 0) ? 32'h3 : 32'h31);
                if (n > 0) chk("rr_interval", 32'(cyc - last_hs), 32'd6);
                last_hs = cyc;
                n++;
                if (n == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("rr_idle", 32'(rsp_valid), 32'd0);

        // Consumer stalls: response stays put and a waiting requester gets no ready.
        issue(1'b0, 32'h12345678, 32'h11111111, 1'b0);
        wait_rsp(lat);
        chk("t4_lat", 32'(lat), 32'd4);
        req1_valid = 1'b1; req1_a = 32'h80000000; req1_b = 32'h80000000; req1_ci = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_sum",   rsp_sum, 32'h23456789);
            chk("stall_id_co", 32'({rsp_id, rsp_co}), 32'd0);
            chk("stall_ready1", 32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("post_hs_ready1", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("t4b_lat", 32'(lat),   32'd4);
        chk("t4b_sum", rsp_sum,    32'h00000000);
        chk("t4b_co",  32'(rsp_co), 32'd1);
        chk("t4b_id",  32'(rsp_id), 32'd1);
        consume();

        // Asynchronous reset in the middle of byte 2.
        issue(1'b1, 32'h01020304, 32'h10203040, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("b2_add_a",  32'(add_a), 32'h02);
        chk("b2_partial", rsp_sum,   32'h00003344);
        rst_n = 1'b0;
        #1;
        chk("arst_add",   32'({add_a, add_b, add_ci}), 32'd0);
        chk("arst_sum",   rsp_sum, 32'h0);
        chk("arst_flags", 32'({rsp_valid, rsp_id, rsp_co}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_norsp", 32'(rsp_valid), 32'd0);
        end
        // Tie immediately after reset goes to requester 0.
        req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h7; req0_ci = 1'b1;
        req1_valid = 1'b1; req1_a = 32'h9; req1_b = 32'h9; req1_ci = 1'b0;
        #1;
        chk("tie_ready0", 32'(req0_ready), 32'd1);
        chk("tie_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("t5_lat", 32'(lat),   32'd4);
        chk("t5_sum", rsp_sum,    32'h0000000D);
        chk("t5_co",  32'(rsp_co), 32'd0);
        chk("t5_id",  32'(rsp_id), 32'd0);
        consume();

`ifdef SUB_EN
        req0_sub = 1'b1;
        issue(1'b0, 32'h00000005, 32'h00000007, 1'b0);
        wait_rsp(lat);
        chk("sub_sum", rsp_sum,     32'hFFFFFFFE);
        chk("sub_co",  32'(rsp_co), 32'd0);
        consume();
        issue(1'b0, 32'h00000007, 32'h00000005, 1'b0);
        wait_rsp(lat);
        chk("sub2_sum", rsp_sum,     32'h00000002);
        chk("sub2_co",  32'(rsp_co), 32'd1);
        consume();
        req0_sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
